// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM controller front end.
//   - sched_state_e : port scheduler state encoding (IDLE=0, OWN=1, DRAIN=2, REFRESH=3)
//   - RefreshCyclesDef, RefUrgentDef, RefMaxDef : default refresh parameters
package sdram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOwn     = 2'd1,
        StDrain   = 2'd2,
        StRefresh = 2'd3
    } sched_state_e;

    localparam int unsigned RefreshCyclesDef = 780;
    localparam int unsigned RefUrgentDef     = 4;
    localparam int unsigned RefMaxDef        = 8;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh bookkeeping: a down-counter producing refresh ticks, a saturating
// count of refreshes still owed, and a sticky flag for ticks lost at saturation.
// Ports:
//   sdram_clk, sdram_rst_n : clock, asynchronous active-low reset
//   ref_ack_i              : one owed refresh has been started (already qualified)
//   ref_pending            : number of owed refreshes
//   ref_urgent             : ref_pending >= REF_URGENT
//   ref_overrun_o          : sticky, a tick arrived while ref_pending == REF_MAX
module sdram_refresh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = RefreshCyclesDef,
    parameter int unsigned REF_URGENT     = RefUrgentDef,
    parameter int unsigned REF_MAX        = RefMaxDef,
    localparam int unsigned PendW         = $clog2(REF_MAX + 1),
    localparam int unsigned TimerW        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1
) (
    input  logic             sdram_clk,
    input  logic             sdram_rst_n,
    input  logic             ref_ack_i,
    output logic [PendW-1:0] ref_pending,
    output logic             ref_urgent,
    output logic             ref_overrun_o
);

    logic [TimerW-1:0] r_timer;
    logic [PendW-1:0]  r_pending;
    logic              r_overrun;
    logic              w_tick;

    assign w_tick = (r_timer == '0);

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_timer <= TimerW'(REFRESH_CYCLES - 1);
        end else if (w_tick) begin
            r_timer <= TimerW'(REFRESH_CYCLES - 1);
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // A tick coinciding with an ack cancels out: one owed refresh added, one retired.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else if (w_tick && !ref_ack_i) begin
            if (r_pending == PendW'(REF_MAX)) begin
                r_overrun <= 1'b1;
            end else begin
                r_pending <= r_pending + 1'b1;
            end
        end else if (!w_tick && ref_ack_i && (r_pending != '0)) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    assign ref_pending   = r_pending;
    assign ref_urgent    = (32'(r_pending) >= REF_URGENT);
    assign ref_overrun_o = r_overrun;

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares the SDRAM controller access interface between WB_PORTS request buffers with
// round-robin grants held across bursts (bounded by a beat quota) and interleaves
// periodic auto-refresh, which preempts port traffic once enough refreshes are owed.
// Ports:
//   sdram_clk, sdram_rst_n : clock, asynchronous active-low reset
//   req_i                  : per-port access request
//   ack_i                  : controller accepted one beat for the current owner
//   sdram_idle_i           : controller idle, no burst in flight
//   grant_o / grant_enc_o  : one-hot / binary current or last owner (drives port mux)
//   grant_valid_o          : owner may drive the controller
//   ref_req_o / ref_ack_i  : refresh request / controller started refresh
//   ref_overrun_o          : sticky, a refresh tick was lost at saturation
module sdram_port_scheduler
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned WB_PORTS       = 3,
    parameter int unsigned QUOTA          = 8,
    parameter int unsigned REFRESH_CYCLES = RefreshCyclesDef,
    parameter int unsigned REF_URGENT     = RefUrgentDef,
    parameter int unsigned REF_MAX        = RefMaxDef,
    localparam int unsigned EncW          = $clog2(WB_PORTS),
    localparam int unsigned BeatW         = $clog2(QUOTA + 1),
    localparam int unsigned PendW         = $clog2(REF_MAX + 1)
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst_n,
    input  logic [WB_PORTS-1:0] req_i,
    input  logic                ack_i,
    input  logic                sdram_idle_i,
    output logic [WB_PORTS-1:0] grant_o,
    output logic [EncW-1:0]     grant_enc_o,
    output logic                grant_valid_o,
    output logic                ref_req_o,
    input  logic                ref_ack_i,
    output logic                ref_overrun_o
);

    sched_state_e        r_state, w_state_d;
    logic [WB_PORTS-1:0] r_grant, w_grant_d;
    logic [EncW-1:0]     r_grant_enc, w_grant_enc_d;
    logic [EncW-1:0]     r_last, w_last_d;
    logic [BeatW-1:0]    r_beats, w_beats_d, w_beats_inc;
    logic                r_grant_valid, w_grant_valid_d;
    logic                r_ref_req, w_ref_req_d;

    logic [PendW-1:0]    w_pending;
    logic                w_urgent;
    logic                w_ref_ack;
    logic                w_other_req;
    logic                w_rr_found;
    logic [EncW-1:0]     w_rr_idx;
    logic [EncW-1:0]     w_cand;

    // Only an ack answering an outstanding request retires an owed refresh.
    assign w_ref_ack = ref_ack_i & r_ref_req;

    sdram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .REF_URGENT     (REF_URGENT),
        .REF_MAX        (REF_MAX)
    ) u_refresh_timer (
        .sdram_clk     (sdram_clk),
        .sdram_rst_n   (sdram_rst_n),
        .ref_ack_i     (w_ref_ack),
        .ref_pending   (w_pending),
        .ref_urgent    (w_urgent),
        .ref_overrun_o (ref_overrun_o)
    );

    // Round-robin: first requester strictly after the last owner, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int unsigned off = 1; off <= WB_PORTS; off++) begin
            w_cand = EncW'((32'(r_last) + off) % WB_PORTS);
            if (!w_rr_found && req_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // Beat count including this cycle's ack, so the quota'th ack ends the grant at once.
    assign w_beats_inc = (r_beats == BeatW'(QUOTA)) ? r_beats : r_beats + BeatW'(ack_i);
    assign w_other_req = |(req_i & ~r_grant);

    always_comb begin
        w_state_d     = r_state;
        w_grant_d     = r_grant;
        w_grant_enc_d = r_grant_enc;
        w_last_d      = r_last;
        w_beats_d     = r_beats;
        w_ref_req_d   = r_ref_req;
        unique case (r_state)
            StIdle: begin
                if (w_urgent || ((w_pending != '0) && !(|req_i))) begin
                    w_state_d   = StRefresh;
                    w_ref_req_d = 1'b1;
                end else if (w_rr_found) begin
                    w_state_d           = StOwn;
                    w_grant_d           = '0;
                    w_grant_d[w_rr_idx] = 1'b1;
                    w_grant_enc_d       = w_rr_idx;
                    w_last_d            = w_rr_idx;
                    w_beats_d           = '0;
                end
            end
            StOwn: begin
                w_beats_d = w_beats_inc;
                if (!req_i[r_grant_enc] || ((w_beats_inc == BeatW'(QUOTA)) && w_other_req)
                    || w_urgent) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                // Grant stays put so read data still routes to the old owner.
                if (sdram_idle_i) begin
                    w_state_d = StIdle;
                end
            end
            StRefresh: begin
                if (r_ref_req) begin
                    if (ref_ack_i) begin
                        w_ref_req_d = 1'b0;
                    end
                end else if (sdram_idle_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        w_grant_valid_d = (w_state_d == StOwn);
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_state       <= StIdle;
            r_grant       <= WB_PORTS'(1);
            r_grant_enc   <= '0;
            r_last        <= EncW'(WB_PORTS - 1);
            r_beats       <= '0;
            r_grant_valid <= 1'b0;
            r_ref_req     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_grant       <= w_grant_d;
            r_grant_enc   <= w_grant_enc_d;
            r_last        <= w_last_d;
            r_beats       <= w_beats_d;
            r_grant_valid <= w_grant_valid_d;
            r_ref_req     <= w_ref_req_d;
        end
    end

    assign grant_o       = r_grant;
    assign grant_enc_o   = r_grant_enc;
    assign grant_valid_o = r_grant_valid;
    assign ref_req_o     = r_ref_req;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Scoreboard bench: the stimulus process drives random traffic, steps a behavioural
// model of the scheduling rules and queues every expected output change with the cycle
// it should appear in; the monitor pops an entry whenever the DUT outputs change.
module tb_sdram_port_scheduler;

    localparam int NP    = 3;
    localparam int QUOTA = 4;
    localparam int RCYC  = 20;
    localparam int RURG  = 2;
    localparam int RMAX  = 4;

    localparam int MS_IDLE  = 0;
    localparam int MS_OWN   = 1;
    localparam int MS_DRAIN = 2;
    localparam int MS_REF   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] req = '0;
    logic          ack = 1'b0;
    logic          idle = 1'b0;
    logic          ref_ack = 1'b0;
    logic [NP-1:0] grant;
    logic [1:0]    grant_enc;
    logic          gv;
    logic          ref_req;
    logic          ovr;

    typedef struct packed {
        int            cyc;
        logic          gv;
        logic [1:0]    enc;
        logic [NP-1:0] grant;
        logic          rr;
        logic          ovr;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    // Behavioural model state
    int            m_st, m_owner, m_last, m_acks, m_pend, m_timer;
    bit            m_ovr, m_refreq, m_gv;
    ev_t           m_prev;
    logic [NP-1:0] req_hold = '1;

    sdram_port_scheduler #(
        .WB_PORTS       (NP),
        .QUOTA          (QUOTA),
        .REFRESH_CYCLES (RCYC),
        .REF_URGENT     (RURG),
        .REF_MAX        (RMAX)
    ) dut (
        .sdram_clk     (clk),
        .sdram_rst_n   (rst_n),
        .req_i         (req),
        .ack_i         (ack),
        .sdram_idle_i  (idle),
        .grant_o       (grant),
        .grant_enc_o   (grant_enc),
        .grant_valid_o (gv),
        .ref_req_o     (ref_req),
        .ref_ack_i     (ref_ack),
        .ref_overrun_o (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(bit g, int enc, bit rr, bit ov);
        ev_t e;
        e.cyc   = 0;
        e.gv    = g;
        e.enc   = 2'(enc);
        e.grant = NP'(1) << enc;
        e.rr    = rr;
        e.ovr   = ov;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_st = MS_IDLE; m_owner = 0; m_last = NP - 1; m_acks = 0;
        m_pend = 0; m_timer = RCYC - 1;
        m_ovr = 0; m_refreq = 0; m_gv = 0;
        m_prev = mk_ev(0, 0, 0, 0);
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        int  n_st = m_st;
        int  n_owner = m_owner;
        int  n_last = m_last;
        int  n_acks = m_acks;
        bit  n_refreq = m_refreq;
        bit  urgent = (m_pend >= RURG);
        bit  tick = (m_timer == 0);
        bit  served = ref_ack && m_refreq;
        bit  others = 0;
        bit  found = 0;
        ev_t e;
        case (m_st)
            MS_IDLE: begin
                if (urgent || (m_pend > 0 && req == '0)) begin
                    n_st = MS_REF; n_refreq = 1;
                end else if (req != '0) begin
                    for (int k = 1; k <= NP; k++) begin
                        if (!found && req[(m_last + k) % NP]) begin
                            found = 1; n_owner = (m_last + k) % NP;
                        end
                    end
                    n_last = n_owner; n_acks = 0; n_st = MS_OWN;
                end
            end
            MS_OWN: begin
                n_acks = m_acks + int'(ack);
                for (int k = 0; k < NP; k++) if (k != m_owner && req[k]) others = 1;
                if (!req[m_owner] || (n_acks >= QUOTA && others) || urgent) n_st = MS_DRAIN;
            end
            MS_DRAIN: if (idle) n_st = MS_IDLE;
            default: begin
                if (m_refreq) begin
                    if (ref_ack) n_refreq = 0;
                end else if (idle) n_st = MS_IDLE;
            end
        endcase
        if (tick && !served) begin
            if (m_pend == RMAX) m_ovr = 1;
            else m_pend++;
        end else if (!tick && served && m_pend > 0) begin
            m_pend--;
        end
        m_timer = tick ? RCYC - 1 : m_timer - 1;
        m_st = n_st; m_owner = n_owner; m_last = n_last; m_acks = n_acks;
        m_refreq = n_refreq; m_gv = (n_st == MS_OWN);
        e = mk_ev(m_gv, m_owner, m_refreq, m_ovr);
        if (e != m_prev) begin
            m_prev = e;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    // Drive one cycle of random inputs (called at a falling edge), then step the model.
    task automatic step_cycle(input logic [NP-1:0] mask, input bit force_req, input bit ref_en);
        for (int p = 0; p < NP; p++) if ($urandom_range(7) == 0) req_hold[p] = ~req_hold[p];
        req     = force_req ? mask : (req_hold & mask);
        ack     = m_gv && req[m_owner] && ($urandom_range(3) != 0);
        idle    = ($urandom_range(2) != 0);
        ref_ack = ref_en && m_refreq && ($urandom_range(1) == 0);
        model_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, int'(grant), 1);
        check({tag, "_grant_enc"}, int'(grant_enc), 0);
        check({tag, "_grant_valid"}, int'(gv), 0);
        check({tag, "_ref_req"}, int'(ref_req), 0);
        check({tag, "_overrun"}, int'(ovr), 0);
    endtask

    // Monitor
    initial begin
        ev_t prev, cur, e;
        prev = mk_ev(0, 0, 0, 0);
        forever begin
            @(posedge clk);
            #1;
            cur.cyc = 0; cur.gv = gv; cur.enc = grant_enc; cur.grant = grant;
            cur.rr = ref_req; cur.ovr = ovr;
            if (!mon_en) begin
                prev = mk_ev(0, 0, 0, 0);
            end else if (cur != prev) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got gv=%0d enc=%0d grant=%b rr=%0d ovr=%0d expected no change",
                             cyc, cur.gv, cur.enc, cur.grant, cur.rr, cur.ovr);
                end else begin
                    e = exp_q.pop_front();
                    cur.cyc = cyc;
                    if (e == cur) n_pass++;
                    else $display("FAIL output_change got cyc=%0d gv=%0d enc=%0d grant=%b rr=%0d ovr=%0d expected cyc=%0d gv=%0d enc=%0d grant=%b rr=%0d ovr=%0d",
                                  cur.cyc, cur.gv, cur.enc, cur.grant, cur.rr, cur.ovr,
                                  e.cyc, e.gv, e.enc, e.grant, e.rr, e.ovr);
                    cur.cyc = 0;
                end
                prev = cur;
            end
        end
    end

    // Stimulus
    initial begin
        int waited;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step_cycle(3'b010, 1, 1);
        // Lone requester: ownership is kept past the quota.
        repeat (40) begin
            @(negedge clk);
            step_cycle(3'b010, 1, 1);
        end
        repeat (600) begin
            @(negedge clk);
            step_cycle('1, 0, 1);
        end
        // Refresh never acknowledged: pending saturates and overrun sets.
        repeat (150) begin
            @(negedge clk);
            step_cycle('1, 0, 0);
        end
        repeat (100) begin
            @(negedge clk);
            step_cycle('1, 0, 1);
        end
        // Asynchronous reset in the middle of a granted burst.
        waited = 0;
        do begin
            @(negedge clk);
            step_cycle('1, 1, 1);
            waited++;
        end while (!m_gv && waited < 300);
        check("reach_own_before_reset", int'(m_gv), 1);
        @(posedge clk);
        #3;
        ack = 1'b1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req_hold = '1;
        mon_en = 1'b1;
        step_cycle('1, 1, 1);
        repeat (300) begin
            @(negedge clk);
            step_cycle('1, 0, 1);
        end
        @(posedge clk);
        #3;
        check("expected_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
